// File: rtl/io_port_team1_pkg.sv
// ============================================================================
//  Module  : io_pkg_team1
//  Brief   : Shared constants and types for the io_port_team1 programmed-I/O port
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package io_pkg_team1;

    localparam int IO_DATA_W = 8;

    typedef enum logic [0:0] {
        O_IDLE = 1'b0,
        O_SEND = 1'b1
    } out_state_t;

    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_DROP     = 1;

endpackage

`default_nettype wire

// File: rtl/io_port_team1_if.sv
// ============================================================================
//  Module  : io_port_team1_if
//  Brief   : Device/CPU signal bundle for io_port_team1 (slave = port side)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface io_port_team1_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dev_in_data;
    logic              dev_in_valid;
    logic              dev_in_ready;
    logic              INP_ACK;
    logic [DATA_W-1:0] out_INPR;
    logic              FGI;
    logic              LD_OUTR;
    logic [DATA_W-1:0] AC_LOW;
    logic [DATA_W-1:0] out_OUTR;
    logic              FGO;
    logic [DATA_W-1:0] dev_out_data;
    logic              dev_out_valid;
    logic              dev_out_ready;
    logic              IEN;
    logic              INTR;
    logic              ERR_CLR;
    logic [1:0]        ERR;

    modport slave (
        input  dev_in_data, dev_in_valid, INP_ACK, LD_OUTR, AC_LOW,
               dev_out_ready, IEN, ERR_CLR,
        output dev_in_ready, out_INPR, FGI, out_OUTR, FGO,
               dev_out_data, dev_out_valid, INTR, ERR
    );

    modport master (
        output dev_in_data, dev_in_valid, INP_ACK, LD_OUTR, AC_LOW,
               dev_out_ready, IEN, ERR_CLR,
        input  dev_in_ready, out_INPR, FGI, out_OUTR, FGO,
               dev_out_data, dev_out_valid, INTR, ERR
    );
endinterface

`default_nettype wire

// File: rtl/io_port_team1_rx_fifo.sv
// ============================================================================
//  Module  : rx_fifo_team1
//  Brief   : DEPTH-entry receive FIFO, head visible combinationally
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_fifo_team1 #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push,
    input  wire logic [DATA_W-1:0] push_data,
    input  wire logic              pop,
    output logic                   full,
    output logic                   empty,
    output logic [DATA_W-1:0]      head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count/pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/io_port_team1.sv
// ============================================================================
//  Module  : io_port_team1
//  Brief   : INPR/FGI + OUTR/FGO programmed-I/O port with receive FIFO and INTR.
//            Optional sticky error flags via `IO_PORT_ERR_FLAGS_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module io_port_team1
    import io_pkg_team1::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = IO_DATA_W
) (
    input  wire logic clk,
    input  wire logic CLR_GLOBAL,
    io_port_team1_if.slave bus
);
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              load;

    logic [DATA_W-1:0] inpr_q, inpr_d;
    logic              fgi_q, fgi_d;
    logic [DATA_W-1:0] outr_q, outr_d;
    out_state_t        state_q, state_d;
    logic              intr_q, intr_d;
    logic              fgo;

    rx_fifo_team1 #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (CLR_GLOBAL),
        .push      (bus.dev_in_valid),
        .push_data (bus.dev_in_data),
        .pop       (load),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // INPR reloads only after FGI has been low for a cycle.
    assign load = ~fgi_q & ~fifo_empty;
    assign fgo  = (state_q == O_IDLE);

    always_comb begin
        inpr_d = inpr_q;
        fgi_d  = fgi_q;
        if (load) begin
            inpr_d = fifo_head;
            fgi_d  = 1'b1;
        end else if (bus.INP_ACK && fgi_q) begin
            fgi_d  = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        outr_d  = outr_q;
        case (state_q)
            O_IDLE: begin
                if (bus.LD_OUTR) begin
                    outr_d  = bus.AC_LOW;
                    state_d = O_SEND;
                end
            end
            O_SEND: begin
                if (bus.dev_out_ready) state_d = O_IDLE;
            end
            default: state_d = O_IDLE;
        endcase
        intr_d = bus.IEN & (fgi_q | fgo);
    end

    always_ff @(posedge clk or posedge CLR_GLOBAL) begin
        if (CLR_GLOBAL) begin
            inpr_q  <= '0;
            fgi_q   <= 1'b0;
            outr_q  <= '0;
            state_q <= O_IDLE;
            intr_q  <= 1'b0;
        end else begin
            inpr_q  <= inpr_d;
            fgi_q   <= fgi_d;
            outr_q  <= outr_d;
            state_q <= state_d;
            intr_q  <= intr_d;
        end
    end

    assign bus.dev_in_ready  = ~fifo_full;
    assign bus.out_INPR      = inpr_q;
    assign bus.FGI           = fgi_q;
    assign bus.out_OUTR      = outr_q;
    assign bus.FGO           = fgo;
    assign bus.dev_out_data  = outr_q;
    assign bus.dev_out_valid = (state_q == O_SEND);
    assign bus.INTR          = intr_q;

`ifdef IO_PORT_ERR_FLAGS_EN
    logic [1:0] err_q, err_d;

    // Set events are applied after the clear so they win in the same cycle.
    always_comb begin
        err_d = err_q;
        if (bus.ERR_CLR) err_d = 2'b00;
        if (bus.INP_ACK && !fgi_q)                err_d[ERR_UNDERRUN] = 1'b1;
        if (bus.LD_OUTR && (state_q == O_SEND))   err_d[ERR_DROP]     = 1'b1;
    end

    always_ff @(posedge clk or posedge CLR_GLOBAL) begin
        if (CLR_GLOBAL) err_q <= 2'b00;
        else            err_q <= err_d;
    end

    assign bus.ERR = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.ERR_CLR;
    assign bus.ERR        = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_port_team1.sv
// ============================================================================
//  Module  : tb_io_port_team1
//  Brief   : Directed self-checking bench for io_port_team1
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_io_port_team1;
    localparam int DATA_W = 8;
`ifdef IO_PORT_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk;
    logic CLR_GLOBAL;
    int   checks;
    int   errors;

    io_port_team1_if #(.DATA_W(DATA_W)) bus ();

    io_port_team1 #(.DEPTH(4), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .CLR_GLOBAL (CLR_GLOBAL),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic       rdy;
        logic [7:0] d;
        checks = 0;
        errors = 0;
        CLR_GLOBAL           = 1'b1;
        bus.dev_in_data      = '0;
        bus.dev_in_valid     = 1'b0;
        bus.INP_ACK          = 1'b0;
        bus.LD_OUTR          = 1'b0;
        bus.AC_LOW           = '0;
        bus.dev_out_ready    = 1'b0;
        bus.IEN              = 1'b1;
        bus.ERR_CLR          = 1'b0;
        tick();
        tick();
        CLR_GLOBAL = 1'b0;

        // reset state
        chk("rst_fgo",   bus.FGO, 1);
        chk("rst_fgi",   bus.FGI, 0);
        chk("rst_intr",  bus.INTR, 0);
        chk("rst_inpr",  bus.out_INPR, 0);
        chk("rst_outr",  bus.out_OUTR, 0);
        chk("rst_oval",  bus.dev_out_valid, 0);
        chk("rst_err",   bus.ERR, 0);
        chk("rst_irdy",  bus.dev_in_ready, 1);
        tick();
        chk("intr_fgo",  bus.INTR, 1);

        // single receive, 2-cycle latency
        bus.dev_in_data  = 8'h41;
        bus.dev_in_valid = 1'b1;
        tick();
        bus.dev_in_valid = 1'b0;
        chk("rx_lat1_fgi", bus.FGI, 0);
        tick();
        chk("rx_fgi",  bus.FGI, 1);
        chk("rx_inpr", bus.out_INPR, 8'h41);
        bus.INP_ACK = 1'b1;
        tick();
        bus.INP_ACK = 1'b0;
        chk("ack_fgi",  bus.FGI, 0);
        chk("ack_inpr", bus.out_INPR, 8'h41);

        // underrun
        bus.INP_ACK = 1'b1;
        tick();
        bus.INP_ACK = 1'b0;
        chk("und_inpr", bus.out_INPR, 8'h41);
        chk("und_fgi",  bus.FGI, 0);
        chk("und_err",  bus.ERR, ERR_EN ? 2'b01 : 2'b00);
        tick();
        chk("und_fgi2", bus.FGI, 0);
        // set beats clear in the same cycle
        bus.ERR_CLR = 1'b1;
        bus.INP_ACK = 1'b1;
        tick();
        bus.INP_ACK = 1'b0;
        chk("setwin_err", bus.ERR, ERR_EN ? 2'b01 : 2'b00);
        tick();
        bus.ERR_CLR = 1'b0;
        chk("clr_err", bus.ERR, 0);

        // interrupt gating by IEN
        bus.IEN = 1'b0;
        tick();
        chk("ien0_intr", bus.INTR, 0);
        bus.IEN = 1'b1;
        tick();
        chk("ien1_intr", bus.INTR, 1);

        // fill FIFO with 0x10.. while holding valid
        d = 8'h10;
        bus.dev_in_data  = d;
        bus.dev_in_valid = 1'b1;
        repeat (6) begin
            rdy = bus.dev_in_ready;
            tick();
            if (rdy) begin
                d = d + 8'h01;
                bus.dev_in_data = d;
            end
        end
        bus.dev_in_valid = 1'b0;
        chk("full_irdy", bus.dev_in_ready, 0);
        chk("full_fgi",  bus.FGI, 1);
        chk("full_inpr", bus.out_INPR, 8'h10);
        chk("full_next", d, 8'h15);
        for (int i = 0; i < 5; i++) begin
            bus.INP_ACK = 1'b1;
            tick();
            bus.INP_ACK = 1'b0;
            chk("drain_gap", bus.FGI, 0);
            tick();
            if (i < 4) begin
                chk("drain_fgi",  bus.FGI, 1);
                chk("drain_inpr", bus.out_INPR, 8'h11 + i);
                chk("drain_irdy", bus.dev_in_ready, 1);
            end else begin
                chk("drain_empty", bus.FGI, 0);
                chk("drain_last",  bus.out_INPR, 8'h14);
            end
        end

        // output handshake
        bus.AC_LOW  = 8'h5A;
        bus.LD_OUTR = 1'b1;
        tick();
        bus.LD_OUTR = 1'b0;
        chk("out_fgo",  bus.FGO, 0);
        chk("out_val",  bus.dev_out_valid, 1);
        chk("out_data", bus.dev_out_data, 8'h5A);
        // dropped write during O_SEND
        bus.AC_LOW  = 8'h33;
        bus.LD_OUTR = 1'b1;
        tick();
        bus.LD_OUTR = 1'b0;
        chk("drop_outr", bus.out_OUTR, 8'h5A);
        chk("drop_err",  bus.ERR, ERR_EN ? 2'b10 : 2'b00);
        tick();
        chk("hold_data", bus.dev_out_data, 8'h5A);
        chk("hold_val",  bus.dev_out_valid, 1);
        chk("hold_intr", bus.INTR, 0);
        bus.dev_out_ready = 1'b1;
        tick();
        chk("done_fgo", bus.FGO, 1);
        chk("done_val", bus.dev_out_valid, 0);
        chk("done_err", bus.ERR, ERR_EN ? 2'b10 : 2'b00);
        tick();
        bus.dev_out_ready = 1'b0;
        chk("idle_rdy_fgo", bus.FGO, 1);
        chk("idle_rdy_val", bus.dev_out_valid, 0);
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        chk("clr2_err", bus.ERR, 0);

        // simultaneous LD_OUTR + dev_out_ready in O_SEND
        bus.AC_LOW  = 8'h21;
        bus.LD_OUTR = 1'b1;
        tick();
        bus.AC_LOW        = 8'h22;
        bus.dev_out_ready = 1'b1;
        tick();
        bus.LD_OUTR       = 1'b0;
        bus.dev_out_ready = 1'b0;
        chk("sim_fgo",  bus.FGO, 1);
        chk("sim_outr", bus.out_OUTR, 8'h21);
        chk("sim_err",  bus.ERR, ERR_EN ? 2'b10 : 2'b00);

        // reset mid-operation
        bus.AC_LOW  = 8'h77;
        bus.LD_OUTR = 1'b1;
        tick();
        bus.LD_OUTR      = 1'b0;
        bus.dev_in_data  = 8'h61;
        bus.dev_in_valid = 1'b1;
        tick();
        bus.dev_in_data  = 8'h62;
        tick();
        bus.dev_in_data  = 8'h63;
        tick();
        bus.dev_in_valid = 1'b0;
        chk("pre_val", bus.dev_out_valid, 1);
        chk("pre_fgi", bus.FGI, 1);
        #1;
        CLR_GLOBAL = 1'b1;
        #1;
        chk("mid_val",  bus.dev_out_valid, 0);
        chk("mid_fgo",  bus.FGO, 1);
        chk("mid_fgi",  bus.FGI, 0);
        chk("mid_irdy", bus.dev_in_ready, 1);
        chk("mid_outr", bus.out_OUTR, 0);
        chk("mid_inpr", bus.out_INPR, 0);
        chk("mid_err",  bus.ERR, 0);
        tick();
        CLR_GLOBAL = 1'b0;
        tick();
        tick();
        chk("post_fgi", bus.FGI, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/io_port_team1.md
Name: io_port_team1

Overview:
Device-side end of the CPU's INPR/FGI and OUTR/FGO programmed-I/O interface. Accepts characters from an external input device into a small receive FIFO. Presents the head character on INPR with FGI set, and retires it when the CPU executes INP. On OUT it captures AC[7:0] into OUTR, clears FGO, and drives a valid/ready handshake to the external output device. It also generates the interrupt request from IEN, FGI and FGO.

Parameters:
DEPTH, 4, receive FIFO entries (power of two, ≥2)
DATA_W, 8, character width; matches INPR/OUTR

Ports:
clk  in  1  system clock, rising edge
CLR_GLOBAL  in  1  asynchronous active-high reset
dev_in_data  in  DATA_W  character from input device
dev_in_valid  in  1  input device offers dev_in_data
dev_in_ready  out  1  FIFO can accept (not full)
INP_ACK  in  1  one-cycle pulse: CPU executed INP (INPR consumed)
out_INPR  out  DATA_W  current input character to CPU
FGI  out  1  input flag: out_INPR holds an unread character
LD_OUTR  in  1  one-cycle pulse: CPU executed OUT
AC_LOW  in  DATA_W  out_AC[7:0]
out_OUTR  out  DATA_W  output register
FGO  out  1  output flag: OUTR free for a new character
dev_out_data  out  DATA_W  character to output device (= out_OUTR)
dev_out_valid  out  1  character pending to output device
dev_out_ready  in  1  output device accepts
IEN  in  1  interrupt enable flip-flop from CPU
INTR  out  1  registered interrupt request
ERR_CLR  in  1  clears ERR flags
ERR  out  2  sticky status (see Optional Feature)

Behaviour:
- Reset (async, CLR_GLOBAL=1):
  - FIFO empty; out_INPR=0, FGI=0, out_OUTR=0, FGO=1, dev_out_valid=0, INTR=0, ERR=0.
  - A reset mid-transfer drops the pending character and any queued input. No partial state survives.
- Receive FIFO:
  - dev_in_ready = ~full.
  - Push on dev_in_valid & dev_in_ready at a rising edge.
  - Pointers wrap modulo DEPTH. A count of DEPTH+1 states distinguishes full from empty.
- INPR load:
  - When FGI=0 and the FIFO is non-empty: out_INPR <= head, pop, FGI <= 1 on the same edge.
  - Latency from device handshake into an empty FIFO to FGI=1 is 2 cycles.
- INP_ACK while FGI=1: FGI <= 0 next edge. out_INPR keeps its value until the next load.
  - A load happens at the earliest on the edge after FGI falls, so there is one cycle with FGI=0 between back-to-back characters.
- INP_ACK while FGI=0: ignored, no state change. ERR[0] is set when the feature is enabled.
- Simultaneous push and pop on a full FIFO: the pop is legal. dev_in_ready was 0, so no push occurs that cycle.
- Output FSM, two states (FGO is the registered flag):
  - O_IDLE: FGO=1, dev_out_valid=0. On LD_OUTR: out_OUTR <= AC_LOW, FGO <= 0, go to O_SEND.
  - O_SEND: FGO=0, dev_out_valid=1, dev_out_data=out_OUTR, held stable until accepted. On dev_out_ready: FGO <= 1, go to O_IDLE.
  - dev_out_ready in O_IDLE is ignored.
- LD_OUTR in O_SEND: ignored; OUTR and the FSM are unchanged. ERR[1] is set when the feature is enabled.
- LD_OUTR and dev_out_ready in the same O_SEND cycle: the handshake completes and the LD_OUTR is dropped, because FGO was 0 when OUT executed.
- Interrupt: INTR <= IEN & (FGI | FGO), registered, one cycle behind its inputs.

Optional Feature:
- Macro IO_PORT_ERR_FLAGS_EN.
- Defined:
  - ERR[0] is a sticky underrun flag (INP_ACK with FGI=0).
  - ERR[1] is a sticky dropped-write flag (LD_OUTR with FGO=0).
  - Both cleared by ERR_CLR. A set event in the same cycle as ERR_CLR wins.
- Undefined: ERR tied to 0, ERR_CLR unused, no flag flops.

Decomposition:
- Package io_pkg_team1:
  - DATA_W default constant.
  - Output FSM state typedef {O_IDLE, O_SEND}.
  - ERR bit index constants ERR_UNDERRUN=0, ERR_DROP=1.
- Sub-module rx_fifo_team1: parameterised DEPTH/DATA_W synchronous FIFO with push/pop/full/empty/head, async reset.
- Top level holds the INPR/FGI load logic, the output FSM, INTR and ERR.

Test Plan:
- Reset, then a single receive:
  - After reset: FGO=1, FGI=0, INTR=0 with IEN=1 until the next edge, then INTR=1 (FGO=1).
  - dev_in 0x41 for one cycle → FGI=1, out_INPR=0x41 two cycles later.
  - INP_ACK → FGI=0 next cycle.
- FIFO full: hold dev_in_valid with 0x10..0x15, no INP_ACK.
  - 0x10 moves to INPR; FIFO holds 0x11..0x14; dev_in_ready=0.
  - INP_ACK ×5 yields 0x11..0x14 in order with no loss.
- Output handshake: LD_OUTR with AC_LOW=0x5A and dev_out_ready=0 for 3 cycles.
  - FGO=0, dev_out_valid=1, dev_out_data=0x5A stable.
  - dev_out_ready=1 → FGO=1 next cycle, dev_out_valid=0.
- Dropped write: second LD_OUTR with AC_LOW=0x33 during O_SEND.
  - out_OUTR stays 0x5A; with IO_PORT_ERR_FLAGS_EN, ERR=2'b10 until ERR_CLR.
- Underrun: INP_ACK with FGI=0.
  - No change to out_INPR or FIFO; ERR[0]=1 when enabled, ERR=0 when not.
- Reset mid-operation: CLR_GLOBAL asserted in O_SEND with 2 queued inputs.
  - Immediately dev_out_valid=0, FGO=1, FGI=0, dev_in_ready=1, out_OUTR=0.
